cache_controller: RTL and testbench

CACHE_CONTROLLER -- requirements
Module: cache_controller

---
 rtl/cache_controller.sv | 169 ++++++++++++++++
 tb/tb_cache_controller.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_controller.sv
// Direct-mapped read-only cache controller: tag compare, 16-beat block fetch, line fill and replayed lookup.
// Optional hit/miss statistics are built only when CACHE_STATS_EN is defined.
module cache_controller #(
    parameter int WORDS = 16,
    parameter int SIZE  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cpu_req,
    input  logic [31:0]             cpu_addr,
    output logic                    cpu_ready,
    output logic [31:0]             cpu_rdata,
    output logic                    cache_mode,
    output logic [7:0]              cache_index,
    output logic [3:0]              cache_blkoffset,
    output logic [19:0]             cache_tagin,
    output logic [WORDS*SIZE-1:0]   cache_datain,
    input  logic [31:0]             cache_dataout,
    input  logic [19:0]             cache_tagout,
    input  logic                    cache_valid,
    output logic                    mem_req,
    output logic [27:0]             mem_addr,
    input  logic                    mem_rvalid,
    input  logic [31:0]             mem_rdata,
    output logic [15:0]             hit_count,
    output logic [15:0]             miss_count
);

    localparam int BW = $clog2(WORDS);
    localparam logic [BW-1:0] LAST_BEAT = BW'(WORDS - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        COMPARE = 3'd1,
        FETCH   = 3'd2,
        FILL    = 3'd3,
        LOOKUP  = 3'd4
    } state_t;

    state_t                  state_q, state_d;
    logic [31:0]             addr_q, addr_d;
    logic [BW-1:0]           beat_q, beat_d;
    logic                    replay_q, replay_d;
    logic [WORDS*SIZE-1:0]   line_q;
    logic                    hit_s;

    assign hit_s        = cache_valid && (cache_tagout == addr_q[31:12]);
    assign mem_addr     = addr_q[31:4];
    assign cache_tagin  = addr_q[31:12];
    assign cache_datain = line_q;

    // Control state, latched request address, beat counter and replay flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            addr_q   <= 32'h0;
            beat_q   <= '0;
            replay_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            beat_q   <= beat_d;
            replay_q <= replay_d;
        end
    end

    // Line assembly buffer; a partial line left by reset is simply overwritten by the next fetch.
    always_ff @(posedge clk) begin
        for (int k = 0; k < WORDS; k++) begin
            if (state_q == FETCH && mem_rvalid && beat_q == BW'(k)) begin
                line_q[k*SIZE +: SIZE] <= mem_rdata;
            end
        end
    end

    // Next-state and storage/CPU/memory command decode.
    always_comb begin
        state_d         = state_q;
        addr_d          = addr_q;
        beat_d          = beat_q;
        replay_d        = replay_q;
        cpu_ready       = 1'b0;
        cpu_rdata       = 32'h0;
        cache_mode      = 1'b0;
        cache_index     = addr_q[11:4];
        cache_blkoffset = addr_q[3:0];
        mem_req         = 1'b0;
        case (state_q)
            IDLE: begin
                // Storage read is launched in the accept cycle so its result lines up with COMPARE.
                cache_index     = cpu_addr[11:4];
                cache_blkoffset = cpu_addr[3:0];
                if (cpu_req) begin
                    addr_d   = cpu_addr;
                    replay_d = 1'b0;
                    state_d  = COMPARE;
                end else begin
                    state_d  = IDLE;
                end
            end
            COMPARE: begin
                if (hit_s) begin
                    cpu_ready = 1'b1;
                    cpu_rdata = cache_dataout;
                    state_d   = IDLE;
                end else begin
                    beat_d    = '0;
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_rvalid) begin
                    beat_d = beat_q + BW'(1);
                    if (beat_q == LAST_BEAT) begin
                        state_d = FILL;
                    end else begin
                        state_d = FETCH;
                    end
                end else begin
                    state_d = FETCH;
                end
            end
            FILL: begin
                cache_mode = 1'b1;
                replay_d   = 1'b1;
                state_d    = LOOKUP;
            end
            LOOKUP: begin
                state_d = COMPARE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef CACHE_STATS_EN
    logic        hit_evt_s;
    logic        miss_evt_s;
    logic [15:0] hit_q;
    logic [15:0] miss_q;

    assign hit_evt_s  = (state_q == COMPARE) && hit_s  && !replay_q;
    assign miss_evt_s = (state_q == COMPARE) && !hit_s && !replay_q;

    // Saturating statistics counters; the replayed compare after a fill is not a new access.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_q  <= 16'h0;
            miss_q <= 16'h0;
        end else begin
            if (hit_evt_s && hit_q != 16'hFFFF) begin
                hit_q <= hit_q + 16'h1;
            end
            if (miss_evt_s && miss_q != 16'hFFFF) begin
                miss_q <= miss_q + 16'h1;
            end
        end
    end

    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`else
    assign hit_count  = 16'h0;
    assign miss_count = 16'h0;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller with a registered storage model and a block-memory responder.
module tb_cache_controller;

    localparam int WORDS = 16;
    localparam int SIZE  = 32;

`ifdef CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                  clk;
    logic                  rst_n;
    logic                  cpu_req;
    logic [31:0]           cpu_addr;
    logic                  cpu_ready;
    logic [31:0]           cpu_rdata;
    logic                  cache_mode;
    logic [7:0]            cache_index;
    logic [3:0]            cache_blkoffset;
    logic [19:0]           cache_tagin;
    logic [WORDS*SIZE-1:0] cache_datain;
    logic [31:0]           cache_dataout;
    logic [19:0]           cache_tagout;
    logic                  cache_valid;
    logic                  mem_req;
    logic [27:0]           mem_addr;
    logic                  mem_rvalid;
    logic [31:0]           mem_rdata;
    logic [15:0]           hit_count;
    logic [15:0]           miss_count;

    cache_controller #(.WORDS(WORDS), .SIZE(SIZE)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata), .cache_mode(cache_mode),
        .cache_index(cache_index), .cache_blkoffset(cache_blkoffset),
        .cache_tagin(cache_tagin), .cache_datain(cache_datain),
        .cache_dataout(cache_dataout), .cache_tagout(cache_tagout), .cache_valid(cache_valid),
        .mem_req(mem_req), .mem_addr(mem_addr), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Storage model: registered read one cycle after cache_mode=0, line write when cache_mode=1.
    logic        tb_preload = 1'b0;
    logic        st_v    [256];
    logic [19:0] st_tag  [256];
    logic [31:0] st_data [256][16];

    always @(posedge clk) begin
        if (tb_preload) begin
            for (int i = 0; i < 256; i++) st_v[i] <= 1'b0;
            st_v[5]   <= 1'b1;
            st_tag[5] <= 20'h00ABC;
            for (int k = 0; k < 16; k++) st_data[5][k] <= 32'h5000 + 32'(k);
            st_data[5][3] <= 32'hDEADBEEF;
        end else if (cache_mode) begin
            for (int k = 0; k < 16; k++) st_data[cache_index][k] <= cache_datain[k*32 +: 32];
            st_tag[cache_index] <= cache_tagin;
            st_v[cache_index]   <= 1'b1;
        end else begin
            cache_dataout <= st_data[cache_index][cache_blkoffset];
            cache_tagout  <= st_tag[cache_index];
            cache_valid   <= st_v[cache_index];
        end
    end

    // Memory responder: word base+k on beat k, optional idle gap, junk valids while mem_req is low.
    logic [31:0] mem_base = 32'h0;
    int          mem_gap  = 0;

    initial begin
        int beat;
        int gap_left;
        beat = 0;
        gap_left = 0;
        mem_rvalid = 1'b0;
        mem_rdata  = 32'h0;
        forever begin
            @(negedge clk);
            if (mem_req) begin
                if (gap_left > 0) begin
                    mem_rvalid = 1'b0;
                    gap_left--;
                end else begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_base + 32'(beat);
                    beat++;
                    gap_left = mem_gap;
                end
            end else begin
                beat = 0;
                gap_left = 0;
                mem_rvalid = 1'b1;
                mem_rdata  = 32'hBAD00BAD;
            end
        end
    end

    // Activity monitor sampled on the active edge.
    int          mreq_cyc  = 0;
    int          mode_cyc  = 0;
    int          beat_cyc  = 0;
    int          mreq_rise = 0;
    logic        mreq_prev = 1'b0;
    logic [19:0] fill_tag  = 20'h0;
    logic [7:0]  fill_idx  = 8'h0;

    always @(posedge clk) begin
        mreq_prev <= mem_req;
        if (mem_req) mreq_cyc <= mreq_cyc + 1;
        if (mem_req && !mreq_prev) mreq_rise <= mreq_rise + 1;
        if (mem_req && mem_rvalid) beat_cyc <= beat_cyc + 1;
        if (cache_mode) begin
            mode_cyc <= mode_cyc + 1;
            fill_tag <= cache_tagin;
            fill_idx <= cache_index;
        end
    end

    task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] d);
        lat = -1;
        d   = 32'h0;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = a;
        @(posedge clk);
        for (int n = 1; n <= 200; n++) begin
            @(negedge clk);
            if (cpu_ready) begin
                lat = n;
                d   = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] base;
        int          gap;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_mreq;
        logic        exp_hit;
    } vec_t;

    vec_t vecs [8];

    initial begin
        int          lat;
        logic [31:0] d;
        logic [31:0] a;
        int          m0, md0, r0, b0;
        int          exp_hits, exp_miss;

        vecs[0] = '{32'h00ABC053, 32'h0,   0, 32'hDEADBEEF, 1,  0,  1'b1};
        vecs[1] = '{32'h00ABC05A, 32'h0,   0, 32'h0000500A, 1,  0,  1'b1};
        vecs[2] = '{32'h1234507A, 32'h100, 0, 32'h0000010A, 20, 16, 1'b0};
        vecs[3] = '{32'h2222213F, 32'h2000,2, 32'h0000200F, 50, 46, 1'b0};
        vecs[4] = '{32'h12345070, 32'h0,   0, 32'h00000100, 1,  0,  1'b1};
        vecs[5] = '{32'h22222131, 32'h0,   0, 32'h00002001, 1,  0,  1'b1};
        vecs[6] = '{32'h00ABD052, 32'h400, 0, 32'h00000402, 20, 16, 1'b0};
        vecs[7] = '{32'h00ABC053, 32'h500, 0, 32'h00000503, 20, 16, 1'b0};

        cpu_req  = 1'b0;
        cpu_addr = 32'h0;
        rst_n    = 1'b0;
        tb_preload = 1'b1;
        @(negedge clk);
        @(negedge clk);
        tb_preload = 1'b0;
        @(negedge clk);
        chk("rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("rst_cache_mode", {31'h0, cache_mode}, 32'h0);
        chk("rst_hit_count", {16'h0, hit_count}, 32'h0);
        chk("rst_miss_count", {16'h0, miss_count}, 32'h0);
        rst_n = 1'b1;

        exp_hits = 0;
        exp_miss = 0;
        for (int i = 0; i < 8; i++) begin
            a        = vecs[i].addr;
            mem_base = vecs[i].base;
            mem_gap  = vecs[i].gap;
            m0 = mreq_cyc; md0 = mode_cyc; r0 = mreq_rise;
            do_read(a, lat, d);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            chk($sformatf("v%0d_rdata", i), d, vecs[i].exp_data);
            chk($sformatf("v%0d_mem_req_cycles", i), 32'(mreq_cyc - m0), 32'(vecs[i].exp_mreq));
            chk($sformatf("v%0d_fill_cycles", i), 32'(mode_cyc - md0), vecs[i].exp_hit ? 32'd0 : 32'd1);
            chk($sformatf("v%0d_mem_req_bursts", i), 32'(mreq_rise - r0), vecs[i].exp_hit ? 32'd0 : 32'd1);
            if (!vecs[i].exp_hit) begin
                chk($sformatf("v%0d_fill_tag", i), {12'h0, fill_tag}, {12'h0, a[31:12]});
                chk($sformatf("v%0d_fill_index", i), {24'h0, fill_idx}, {24'h0, a[11:4]});
                chk($sformatf("v%0d_mem_addr", i), {4'h0, mem_addr}, {4'h0, a[31:4]});
                exp_miss++;
            end else begin
                exp_hits++;
            end
        end
        chk("table_hit_count", {16'h0, hit_count}, STATS ? 32'(exp_hits) : 32'h0);
        chk("table_miss_count", {16'h0, miss_count}, STATS ? 32'(exp_miss) : 32'h0);

        // Reset in the middle of a fetch, right after beat 7 is captured.
        mem_base = 32'h3000;
        mem_gap  = 0;
        md0 = mode_cyc;
        b0  = beat_cyc;
        @(negedge clk);
        cpu_req  = 1'b1;
        cpu_addr = 32'h33333040;
        lat = -1;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (beat_cyc - b0 >= 8) begin
                lat = n;
                break;
            end
        end
        chk("midfetch_reached_beat7", {31'h0, lat >= 0}, 32'h1);
        cpu_req = 1'b0;
        rst_n   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        chk("midfetch_rst_mem_req", {31'h0, mem_req}, 32'h0);
        chk("midfetch_rst_cpu_ready", {31'h0, cpu_ready}, 32'h0);
        chk("midfetch_rst_hit_count", {16'h0, hit_count}, 32'h0);
        chk("midfetch_rst_miss_count", {16'h0, miss_count}, 32'h0);
        repeat (3) @(negedge clk);
        chk("midfetch_mem_req_idle", {31'h0, mem_req}, 32'h0);
        chk("midfetch_no_fill", 32'(mode_cyc - md0), 32'h0);

        // Post-reset: one miss (the discarded line is refetched whole), then one hit.
        m0 = mreq_cyc;
        do_read(32'h33333045, lat, d);
        chk("post_rst_miss_latency", 32'(lat), 32'd20);
        chk("post_rst_miss_rdata", d, 32'h00003005);
        chk("post_rst_mem_req_cycles", 32'(mreq_cyc - m0), 32'd16);
        do_read(32'h33333041, lat, d);
        chk("post_rst_hit_latency", 32'(lat), 32'd1);
        chk("post_rst_hit_rdata", d, 32'h00003001);
        chk("stats_hit_count", {16'h0, hit_count}, STATS ? 32'd1 : 32'd0);
        chk("stats_miss_count", {16'h0, miss_count}, STATS ? 32'd1 : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
